// File: rtl/hps_data_out_ptr_ctrl.sv
// Pointer controller for the HPS data-out circular buffer; HPS drains it over Avalon-MM.
// Pointers and registers update one edge after the handshake or write; irq is registered one cycle later.
// wr_ready drops when disabled or full; wr_valid while full is dropped and sets overflow. Option: HPS_PTR_WATERMARK_EN.
module hps_data_out_ptr_ctrl #(
    parameter int ADDR_W         = 9,
    parameter int DEFAULT_THRESH = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_write_n,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              irq
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    logic [ADDR_W:0] wptr_q, wptr_d, rptr_q, rptr_d, thresh_q, thresh_d;
    logic            enable_q, enable_d, irq_en_q, irq_en_d;
    logic            overflow_q, overflow_d, irq_q, irq_d;
    logic [ADDR_W:0] level, adv;
    logic            empty, full, thresh_hit, reg_wr;
    logic            unused_wdata;

    assign level      = wptr_q - rptr_q;
    assign empty      = (level == '0);
    assign full       = (level == DEPTH);
    assign thresh_hit = (thresh_q != '0) && (level >= thresh_q);
    assign reg_wr     = avs_chipselect & ~avs_write_n;
    assign adv        = avs_writedata[ADDR_W:0];
    assign unused_wdata = ^avs_writedata[31:ADDR_W+1];

    assign wr_ready = enable_q & ~full;
    assign wr_en    = wr_valid & wr_ready;
    assign wr_addr  = wptr_q[ADDR_W-1:0];
    assign rd_ptr   = rptr_q[ADDR_W-1:0];
    assign irq      = irq_q;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        thresh_d   = thresh_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        irq_d      = irq_en_q & (thresh_hit | overflow_q);

        if (wr_en)
            wptr_d = wptr_q + 1'b1;
        if (wr_valid & enable_q & full)
            overflow_d = 1'b1;

        if (reg_wr) begin
            case (avs_address)
                3'd0: begin
                    enable_d = avs_writedata[0];
                    irq_en_d = avs_writedata[1];
                    // Clear overrides any sample accepted in the same cycle.
                    if (avs_writedata[2]) begin
                        wptr_d     = '0;
                        rptr_d     = '0;
                        overflow_d = 1'b0;
                    end
                end
                3'd1: if (avs_writedata[2]) overflow_d = 1'b0;
                3'd3: rptr_d = (adv > level) ? wptr_q : rptr_q + adv;
                3'd4: thresh_d = adv;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            thresh_q   <= (ADDR_W+1)'(DEFAULT_THRESH);
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            thresh_q   <= thresh_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

`ifdef HPS_PTR_WATERMARK_EN
    logic [ADDR_W:0] peak_q, peak_d;

    always_comb begin
        peak_d = (level > peak_q) ? level : peak_q;
        if (reg_wr && ((avs_address == 3'd6) || (avs_address == 3'd0 && avs_writedata[2])))
            peak_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) peak_q <= '0;
        else          peak_q <= peak_d;
    end
`endif

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            3'd0: avs_readdata = {30'd0, irq_en_q, enable_q};
            3'd1: avs_readdata = {28'd0, thresh_hit, overflow_q, full, empty};
            3'd2: avs_readdata = {{(31-ADDR_W){1'b0}}, level};
            3'd3: avs_readdata = {{(32-ADDR_W){1'b0}}, rptr_q[ADDR_W-1:0]};
            3'd4: avs_readdata = {{(31-ADDR_W){1'b0}}, thresh_q};
            3'd5: avs_readdata = {{(32-ADDR_W){1'b0}}, wptr_q[ADDR_W-1:0]};
`ifdef HPS_PTR_WATERMARK_EN
            3'd6: avs_readdata = {{(31-ADDR_W){1'b0}}, peak_q};
`endif
            default: avs_readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_hps_data_out_ptr_ctrl.sv
// Directed bench for hps_data_out_ptr_ctrl; RAM write addresses are checked against a queue of expected addresses.
module tb_hps_data_out_ptr_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [8:0]  rd_ptr;
    logic        irq;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_addr;
    logic [9:0] mw = '0;
    logic [9:0] mr = '0;

    hps_data_out_ptr_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write_n(avs_write_n), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .rd_ptr(rd_ptr), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each accepted sample must appear as wr_en with the next queued address.
    always @(negedge clk) begin
        if (wr_en) begin
            if (sb.size() == 0)
                check("wr_en_unexpected", {31'd0, wr_en}, 32'd0);
            else begin
                exp_addr = sb.pop_front();
                check("wr_addr", {23'd0, wr_addr}, {23'd0, exp_addr});
            end
        end else if (sb.size() != 0) begin
            check("wr_en_missing", {31'd0, wr_en}, 32'd1);
            sb.delete();
        end
    end

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        avs_address = a; avs_chipselect = 1'b1; avs_write_n = 1'b1;
        #1;
        check(tag, avs_readdata, exp);
        @(posedge clk); #1;
        avs_chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write_n = 1'b0;
        @(posedge clk); #1;
        avs_chipselect = 1'b0; avs_write_n = 1'b1;
    endtask

    task automatic send(input int n);
        logic [9:0] lv;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            lv = mw - mr;
            if (lv != 10'd512) begin
                sb.push_back(mw[8:0]);
                mw = mw + 10'd1;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; avs_address = '0; avs_chipselect = 1'b0; avs_write_n = 1'b1;
        avs_writedata = '0; wr_valid = 1'b0;
        #12;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
        check("rst_rd_ptr", {23'd0, rd_ptr}, 32'd0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        rd(3'd0, 32'd0, "rst_ctrl");
        rd(3'd1, 32'h1, "rst_status");
        rd(3'd2, 32'd0, "rst_level");
        rd(3'd3, 32'd0, "rst_rdptr_reg");
        rd(3'd4, 32'd256, "rst_thresh");
        rd(3'd5, 32'd0, "rst_wrptr_reg");
        rd(3'd6, 32'd0, "rst_addr6");
        rd(3'd7, 32'd0, "rst_addr7");

        // Disabled: wr_valid ignored, no overflow
        wr_valid = 1'b1; @(posedge clk); #1; wr_valid = 1'b0;
        rd(3'd1, 32'h1, "disabled_status");

        // Basic writes and advance
        wr(3'd0, 32'h1);
        check("en_wr_ready", {31'd0, wr_ready}, 32'd1);
        send(10);
        rd(3'd2, 32'd10, "level10");
        rd(3'd5, 32'd10, "wrptr10");
        wr(3'd3, 32'd4); mr = mr + 10'd4;
        check("rd_ptr4", {23'd0, rd_ptr}, 32'd4);
        rd(3'd2, 32'd6, "level6");

        // Fill, overflow, W1C
        wr(3'd0, 32'h5); mw = '0; mr = '0;
        rd(3'd2, 32'd0, "level_after_clear");
        send(512);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        rd(3'd1, 32'hA, "status_full");
        rd(3'd2, 32'd512, "level512");
        check("full_irq_dis", {31'd0, irq}, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd0, 32'h3);
        rd(3'd4, 32'd0, "thresh0");
        check("irq_no_cause", {31'd0, irq}, 32'd0);
        send(1);
        check("ovf_irq_lat", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("ovf_irq", {31'd0, irq}, 32'd1);
        rd(3'd1, 32'h6, "status_ovf");
        rd(3'd2, 32'd512, "level_ovf");
        wr(3'd1, 32'h4);
        rd(3'd1, 32'h2, "status_w1c");
        check("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Wrap and clamp
        wr(3'd3, 32'd500); mr = mr + 10'd500;
        rd(3'd2, 32'd12, "level12");
        check("rd_ptr500", {23'd0, rd_ptr}, 32'd500);
        send(20);
        rd(3'd2, 32'd32, "level32");
        rd(3'd5, 32'd20, "wrptr_wrap");
        wr(3'd3, 32'd100); mr = mw;
        check("rd_ptr_clamp", {23'd0, rd_ptr}, 32'd20);
        rd(3'd1, 32'h1, "status_clamp_empty");
        rd(3'd2, 32'd0, "level_clamp");
        rd(3'd3, 32'd20, "rdptr_reg_clamp");

        // Simultaneous write and advance
        send(5);
        rd(3'd2, 32'd5, "level5");
        wr_valid = 1'b1; sb.push_back(mw[8:0]); mw = mw + 10'd1;
        wr(3'd3, 32'd1); mr = mr + 10'd1;
        wr_valid = 1'b0;
        rd(3'd2, 32'd5, "level_simul");
        check("rd_ptr_simul", {23'd0, rd_ptr}, 32'd21);
        rd(3'd5, 32'd26, "wrptr_simul");
        check("irq_thresh0", {31'd0, irq}, 32'd0);

        // Clear with a sample in flight
        wr_valid = 1'b1; sb.push_back(mw[8:0]);
        wr(3'd0, 32'h7); mw = '0; mr = '0;
        wr_valid = 1'b0;
        rd(3'd2, 32'd0, "level_clr");
        rd(3'd1, 32'h1, "status_clr");
        rd(3'd5, 32'd0, "wrptr_clr");
        rd(3'd0, 32'h3, "ctrl_clr");
        check("rd_ptr_clr", {23'd0, rd_ptr}, 32'd0);

        // Threshold interrupt
        wr(3'd4, 32'd8);
        rd(3'd4, 32'd8, "thresh8");
        for (int i = 0; i < 7; i++) begin
            send(1);
            check("irq_below_thresh", {31'd0, irq}, 32'd0);
        end
        @(posedge clk); #1;
        check("irq_level7", {31'd0, irq}, 32'd0);
        send(1);
        check("irq_thresh_lat", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_thresh", {31'd0, irq}, 32'd1);
        rd(3'd1, 32'h8, "status_thresh");
        wr(3'd3, 32'd1); mr = mr + 10'd1;
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_deassert", {31'd0, irq}, 32'd0);

        // Asynchronous reset mid-transfer
        wr_valid = 1'b1; sb.push_back(mw[8:0]);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        check("arst_wr_en", {31'd0, wr_en}, 32'd0);
        check("arst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("arst_wr_addr", {23'd0, wr_addr}, 32'd0);
        check("arst_rd_ptr", {23'd0, rd_ptr}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        wr_valid = 1'b0; mw = '0; mr = '0;
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd0, 32'd0, "arst_ctrl");
        rd(3'd2, 32'd0, "arst_level");
        rd(3'd4, 32'd256, "arst_thresh");
        rd(3'd1, 32'h1, "arst_status");

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
